fpaddsub_result_stage: RTL and testbench

Registered output stage placed directly downstream of the add/sub exception module. It accepts each final result `P[31:0]` and its 5-bit exception flag vector, and buffers them in a 2-entry FIFO behind a valid/ready handshake. It optionally canonicalises NaN results and maintains IEEE-style sticky exception flags plus a saturating exception-event counter for software readout. This is the first clocked point after the combinational add/sub datapath tail.

---
 rtl/fpaddsub_pkg.sv | 18 +
 rtl/fpaddsub_skid_fifo.sv | 61 ++++++
 rtl/fpaddsub_result_stage.sv | 75 +++++++
 tb/tb_fpaddsub_result_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fpaddsub_pkg.sv
// Shared definitions for the add/sub result stage: flag bit positions,
// the canonical quiet NaN and the buffered entry layout.
package fpaddsub_pkg;

    localparam int unsigned FLG_OVF = 4;
    localparam int unsigned FLG_UNF = 3;
    localparam int unsigned FLG_DBZ = 2;
    localparam int unsigned FLG_INV = 1;
    localparam int unsigned FLG_INX = 0;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  flags;
    } entry_t;

endpackage

// File: rtl/fpaddsub_skid_fifo.sv
// Two-entry register FIFO with head/tail pointers; ready/valid decode only
// from the occupancy register, and the head output holds while empty.
module fpaddsub_skid_fifo
    import fpaddsub_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_valid,
    output logic   push_ready,
    input  entry_t push_data,
    output logic   pop_valid,
    input  logic   pop_ready,
    output entry_t pop_data
);

    entry_t     mem_q [2];
    entry_t     mem_d [2];
    logic       head_q, head_d;
    logic       tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    assign push_ready = (count_q != 2'd2);
    assign pop_valid  = (count_q != 2'd0);
    assign push       = push_valid & push_ready;
    assign pop        = pop_valid & pop_ready;

    // When empty, the slot behind head is the last entry popped, which a push
    // into an empty FIFO (it writes at head) can never overwrite.
    assign pop_data = (count_q == 2'd0) ? mem_q[~head_q] : mem_q[head_q];

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + 2'(push) - 2'(pop);
        if (push) begin
            mem_d[tail_q] = push_data;
            tail_d        = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fpaddsub_result_stage.sv
// Registered output stage after the add/sub exception logic: NaN
// canonicalisation, 2-entry buffering, sticky flags and exception counter.
module fpaddsub_result_stage
    import fpaddsub_pkg::*;
#(
    parameter bit          CANON_NAN = 1'b1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      P,
    input  logic [4:0]       Flags,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [31:0]      Result,
    output logic [4:0]       OutFlags,
    input  logic             ClearSticky,
    output logic [4:0]       StickyFlags,
    output logic [CNT_W-1:0] ExcCount
);

    entry_t             in_entry;
    entry_t             head_entry;
    logic               deliver;
    logic [4:0]         sticky_q, sticky_d;
    logic [CNT_W-1:0]   exc_cnt_q, exc_cnt_d;

    always_comb begin
        in_entry.flags  = Flags;
        in_entry.result = (CANON_NAN && Flags[FLG_INV]) ? QNAN : P;
    end

    fpaddsub_skid_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (InValid),
        .push_ready (InReady),
        .push_data  (in_entry),
        .pop_valid  (OutValid),
        .pop_ready  (OutReady),
        .pop_data   (head_entry)
    );

    assign Result   = head_entry.result;
    assign OutFlags = head_entry.flags;
    assign deliver  = OutValid & OutReady;

    // Clear is applied first so a coincident delivery is still accumulated.
    always_comb begin
        sticky_d  = ClearSticky ? '0 : sticky_q;
        exc_cnt_d = ClearSticky ? '0 : exc_cnt_q;
        if (deliver) begin
            sticky_d = sticky_d | OutFlags;
            if ((OutFlags[FLG_OVF] | OutFlags[FLG_INV]) && (exc_cnt_d != '1)) begin
                exc_cnt_d = exc_cnt_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q  <= '0;
            exc_cnt_q <= '0;
        end else begin
            sticky_q  <= sticky_d;
            exc_cnt_q <= exc_cnt_d;
        end
    end

    assign StickyFlags = sticky_q;
    assign ExcCount    = exc_cnt_q;

endmodule

// File: tb/tb_fpaddsub_result_stage.sv
// Self-checking bench for fpaddsub_result_stage: queue-based reference model
// compared every cycle, plus directed literal checks from the test plan.
module tb_fpaddsub_result_stage;

    localparam int unsigned CNT_W = 8;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             InValid = 1'b0;
    logic             InReady;
    logic [31:0]      P = '0;
    logic [4:0]       Flags = '0;
    logic             OutValid;
    logic             OutReady = 1'b0;
    logic [31:0]      Result;
    logic [4:0]       OutFlags;
    logic             ClearSticky = 1'b0;
    logic [4:0]       StickyFlags;
    logic [CNT_W-1:0] ExcCount;

    logic             nc_InReady, nc_OutValid;
    logic [31:0]      nc_Result;
    logic [4:0]       nc_OutFlags, nc_StickyFlags;
    logic [CNT_W-1:0] nc_ExcCount;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    fpaddsub_result_stage #(.CANON_NAN(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
        .P(P), .Flags(Flags), .OutValid(OutValid), .OutReady(OutReady),
        .Result(Result), .OutFlags(OutFlags), .ClearSticky(ClearSticky),
        .StickyFlags(StickyFlags), .ExcCount(ExcCount)
    );

    fpaddsub_result_stage #(.CANON_NAN(1'b0), .CNT_W(CNT_W)) dut_nc (
        .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(nc_InReady),
        .P(P), .Flags(Flags), .OutValid(nc_OutValid), .OutReady(OutReady),
        .Result(nc_Result), .OutFlags(nc_OutFlags), .ClearSticky(ClearSticky),
        .StickyFlags(nc_StickyFlags), .ExcCount(nc_ExcCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored entries plus the last value shown.
    logic [36:0] mq[$];
    logic [31:0] m_last_res;
    logic [4:0]  m_last_flg;
    logic [4:0]  m_sticky;
    int          m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_last_res = '0;
            m_last_flg = '0;
            m_sticky   = '0;
            m_cnt      = 0;
        end else begin
            bit can_acc, can_del;
            logic [36:0] h;
            can_acc = (mq.size() < 2);
            can_del = (mq.size() > 0) && OutReady;
            if (ClearSticky) begin
                m_sticky = '0;
                m_cnt    = 0;
            end
            if (can_del) begin
                h = mq.pop_front();
                m_last_res = h[36:5];
                m_last_flg = h[4:0];
                m_sticky   = m_sticky | h[4:0];
                if ((h[4] || h[1]) && m_cnt < CMAX) m_cnt++;
            end
            if (InValid && can_acc)
                mq.push_back({(Flags[1] ? 32'h7FC00000 : P), Flags});
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("m_outvalid", {31'd0, OutValid}, {31'd0, mq.size() != 0});
            chk("m_inready",  {31'd0, InReady},  {31'd0, mq.size() != 2});
            chk("m_result",   Result,   (mq.size() != 0) ? mq[0][36:5] : m_last_res);
            chk("m_outflags", {27'd0, OutFlags}, {27'd0, (mq.size() != 0) ? mq[0][4:0] : m_last_flg});
            chk("m_sticky",   {27'd0, StickyFlags}, {27'd0, m_sticky});
            chk("m_exccount", {24'd0, ExcCount}, 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        InValid = 1'b0; OutReady = 1'b0; ClearSticky = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();
        cmp_en = 1'b1;
        chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
        chk("rst_inready",  {31'd0, InReady},  32'd1);
        chk("rst_result",   Result, 32'd0);
        chk("rst_sticky",   {27'd0, StickyFlags}, 32'd0);

        // Single push and delivery
        P = 32'h3F800000; Flags = 5'b00001; InValid = 1'b1; OutReady = 1'b1;
        tick();
        InValid = 1'b0;
        chk("single_valid",  {31'd0, OutValid}, 32'd1);
        chk("single_result", Result, 32'h3F800000);
        tick();
        chk("single_sticky", {27'd0, StickyFlags}, 32'h01);

        // Invalid canonicalisation on both parameterisations
        do_reset();
        P = 32'h7F812345; Flags = 5'b00010; InValid = 1'b1; OutReady = 1'b1;
        tick();
        InValid = 1'b0;
        chk("canon_result",  Result,    32'h7FC00000);
        chk("nocanon_result", nc_Result, 32'h7F812345);
        tick();
        chk("canon_exccount", {24'd0, ExcCount}, 32'd1);

        // Back-pressure: three pushes against a stalled output
        do_reset();
        OutReady = 1'b0; InValid = 1'b1; Flags = 5'b00000;
        P = 32'h00000A0A; tick();
        P = 32'h00000B0B; tick();
        chk("bp_full_inready", {31'd0, InReady}, 32'd0);
        P = 32'h00000C0C; tick();
        chk("bp_hold_result", Result, 32'h00000A0A);
        OutReady = 1'b1;
        tick();
        chk("bp_second", Result, 32'h00000B0B);
        tick();
        InValid = 1'b0;
        chk("bp_third", Result, 32'h00000C0C);
        tick();
        chk("bp_drained", {31'd0, OutValid}, 32'd0);

        // Streaming 100 back-to-back random results
        OutReady = 1'b1; InValid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            P = $urandom; Flags = 5'($urandom);
            tick();
        end
        InValid = 1'b0;
        tick();

        // Counter saturation, then clear coincident with a delivery
        do_reset();
        OutReady = 1'b1; InValid = 1'b1; Flags = 5'b10000;
        for (int i = 0; i < 300; i++) begin
            P = $urandom;
            tick();
        end
        chk("sat_exccount", {24'd0, ExcCount}, 32'd255);
        Flags = 5'b01000; P = 32'h12345678;
        tick();
        InValid = 1'b0; ClearSticky = 1'b1;
        tick();
        ClearSticky = 1'b0;
        chk("clr_sticky",   {27'd0, StickyFlags}, 32'h08);
        chk("clr_exccount", {24'd0, ExcCount}, 32'd0);

        // Asynchronous reset while full
        OutReady = 1'b0; InValid = 1'b1; P = 32'hDEADBEEF; Flags = 5'b00000;
        tick(); tick();
        InValid = 1'b0;
        chk("pre_rst_full", {31'd0, InReady}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outvalid", {31'd0, OutValid}, 32'd0);
        chk("arst_inready",  {31'd0, InReady},  32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_no_stale", {31'd0, OutValid}, 32'd0);
        end

        // Random traffic with occasional clears
        for (int i = 0; i < 3000; i++) begin
            InValid     = ($urandom_range(0, 3) != 0);
            OutReady    = ($urandom_range(0, 2) != 0);
            ClearSticky = ($urandom_range(0, 40) == 0);
            P           = $urandom;
            Flags       = 5'($urandom);
            tick();
        end
        InValid = 1'b0; ClearSticky = 1'b0; OutReady = 1'b1;
        tick(); tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
